flash_read_sequencer: RTL and testbench

Upstream command stage for the QSPI flash read path (`top_read`). It accepts one byte-range read request (base address, length, bus mode) from the host-side controller. It splits the range into chunk-aligned sub-reads that never cross a chunk or die boundary. It then issues each sub-read to `top_read` through its `start_addr`/`end_addr`/`mode`/`switch_die_need`/`read_req` inputs, waits for `busy`/`completed`, and reports overall done or error.

---
 rtl/flash_read_sequencer.sv | 179 +++++++++++++++++
 tb/tb_flash_read_sequencer.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_read_sequencer.sv
// Splits one host byte-range read into chunk-aligned sub-reads for top_read.
// Each sub-read is issued, acknowledged through busy/completed, and counted.
module flash_read_sequencer #(
  parameter int DIE_LOG2    = 25,
  parameter int CHUNK_LOG2  = 8,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic        CLK_25M_CKMNG_MAIN_PLD,
  input  logic        PWRGD_P1V2_MAX10_AUX_PLD_R,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_len,
  input  logic [1:0]  req_mode,
  input  logic        abort,
  output logic [31:0] rd_start_addr,
  output logic [31:0] rd_end_addr,
  output logic [1:0]  rd_mode,
  output logic        rd_switch_die_need,
  output logic        rd_read_req,
  input  logic        rd_busy,
  input  logic        rd_completed,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code,
  output logic [15:0] chunk_cnt
);

  localparam int          DIE_W      = 32 - DIE_LOG2;
  localparam logic [31:0] CHUNK_MASK = (32'd1 << CHUNK_LOG2) - 32'd1;
  localparam logic [31:0] TO_LAST    = 32'(TIMEOUT_CYC - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_CHECK     = 3'd1;
  localparam logic [2:0] S_ISSUE     = 3'd2;
  localparam logic [2:0] S_WAIT_ACK  = 3'd3;
  localparam logic [2:0] S_WAIT_DONE = 3'd4;
  localparam logic [2:0] S_NEXT      = 3'd5;
  localparam logic [2:0] S_FINISH    = 3'd6;

  logic             clk;
  logic             rst;
  logic [2:0]       state;
  logic [31:0]      addr_lat;
  logic [1:0]       mode_lat;
  logic [32:0]      req_end;
  logic             len_zero;
  logic [DIE_W-1:0] last_die;
  logic [31:0]      tcnt;

  logic             bad_req;
  logic             last_chunk;
  logic             load_issue;
  logic [31:0]      cur_nxt;
  logic [31:0]      end_nxt;
  logic [DIE_W-1:0] die_nxt;

  assign clk = CLK_25M_CKMNG_MAIN_PLD;
  assign rst = PWRGD_P1V2_MAX10_AUX_PLD_R;

  assign req_ready   = (state == S_IDLE);
  assign busy        = (state != S_IDLE);
  assign rd_read_req = (state == S_ISSUE);
  assign done        = (state == S_FINISH);

  function automatic logic [31:0] sub_end(input logic [31:0] cur, input logic [31:0] last);
    logic [31:0] chunk_end;
    chunk_end = cur | CHUNK_MASK;
    return (chunk_end > last) ? last : chunk_end;
  endfunction

  // Next sub-read start: the request base after CHECK, else one past the last issued end.
  always_comb begin
    bad_req    = len_zero || (mode_lat == 2'b11) || req_end[32];
    last_chunk = (rd_end_addr == req_end[31:0]);
    cur_nxt    = (state == S_CHECK) ? addr_lat : rd_end_addr + 32'd1;
    end_nxt    = sub_end(cur_nxt, req_end[31:0]);
    die_nxt    = cur_nxt[31:DIE_LOG2];
    load_issue = !abort && (((state == S_CHECK) && !bad_req) ||
                            ((state == S_NEXT) && !last_chunk));
  end

  // Command registers hold between issues; last_die survives across requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_start_addr      <= '0;
      rd_end_addr        <= '0;
      rd_mode            <= '0;
      rd_switch_die_need <= 1'b0;
      last_die           <= '0;
    end else if (load_issue) begin
      rd_start_addr      <= cur_nxt;
      rd_end_addr        <= end_nxt;
      rd_mode            <= mode_lat;
      rd_switch_die_need <= (die_nxt != last_die);
      last_die           <= die_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      error     <= 1'b0;
      err_code  <= 2'b00;
      chunk_cnt <= '0;
      addr_lat  <= '0;
      mode_lat  <= '0;
      req_end   <= '0;
      len_zero  <= 1'b0;
      tcnt      <= '0;
    end else begin
      error <= 1'b0;
      if ((state != S_IDLE) && abort) begin
        state    <= S_IDLE;
        error    <= 1'b1;
        err_code <= 2'b11;
      end else begin
        case (state)
          S_IDLE: begin
            if (req_valid) begin
              addr_lat  <= req_addr;
              mode_lat  <= req_mode;
              req_end   <= {1'b0, req_addr} + {1'b0, req_len} - 33'd1;
              len_zero  <= (req_len == 32'd0);
              chunk_cnt <= '0;
              err_code  <= 2'b00;
              state     <= S_CHECK;
            end
          end
          S_CHECK: begin
            if (bad_req) begin
              error    <= 1'b1;
              err_code <= 2'b01;
              state    <= S_IDLE;
            end else begin
              state <= S_ISSUE;
            end
          end
          S_ISSUE: begin
            tcnt  <= '0;
            state <= S_WAIT_ACK;
          end
          // Waiting for busy first keeps a stale completed from the previous sub-read out.
          S_WAIT_ACK: begin
            if (rd_busy) begin
              tcnt  <= '0;
              state <= S_WAIT_DONE;
            end else if (tcnt == TO_LAST) begin
              error    <= 1'b1;
              err_code <= 2'b10;
              state    <= S_IDLE;
            end else begin
              tcnt <= tcnt + 32'd1;
            end
          end
          S_WAIT_DONE: begin
            if (rd_completed) begin
              state <= S_NEXT;
            end else if (tcnt == TO_LAST) begin
              error    <= 1'b1;
              err_code <= 2'b10;
              state    <= S_IDLE;
            end else begin
              tcnt <= tcnt + 32'd1;
            end
          end
          S_NEXT: begin
            if (chunk_cnt != 16'hFFFF) chunk_cnt <= chunk_cnt + 16'd1;
            state <= last_chunk ? S_FINISH : S_ISSUE;
          end
          S_FINISH: state <= S_IDLE;
          default:  state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_flash_read_sequencer.sv
// Directed scenarios for flash_read_sequencer; inputs driven and outputs sampled on the falling edge.
module tb_flash_read_sequencer;

  localparam int TO = 30;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [31:0] req_len = '0;
  logic [1:0]  req_mode = '0;
  logic        abort = 1'b0;
  logic [31:0] rd_start_addr;
  logic [31:0] rd_end_addr;
  logic [1:0]  rd_mode;
  logic        rd_switch_die_need;
  logic        rd_read_req;
  logic        rd_busy = 1'b0;
  logic        rd_completed = 1'b0;
  logic        busy;
  logic        done;
  logic        error;
  logic [1:0]  err_code;
  logic [15:0] chunk_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  flash_read_sequencer #(
    .DIE_LOG2(25),
    .CHUNK_LOG2(8),
    .TIMEOUT_CYC(TO)
  ) dut (
    .CLK_25M_CKMNG_MAIN_PLD(clk),
    .PWRGD_P1V2_MAX10_AUX_PLD_R(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr(req_addr),
    .req_len(req_len),
    .req_mode(req_mode),
    .abort(abort),
    .rd_start_addr(rd_start_addr),
    .rd_end_addr(rd_end_addr),
    .rd_mode(rd_mode),
    .rd_switch_die_need(rd_switch_die_need),
    .rd_read_req(rd_read_req),
    .rd_busy(rd_busy),
    .rd_completed(rd_completed),
    .busy(busy),
    .done(done),
    .error(error),
    .err_code(err_code),
    .chunk_cnt(chunk_cnt)
  );

  // Called at a falling edge in IDLE; returns at the falling edge of the CHECK cycle.
  task automatic send(input logic [31:0] a, input logic [31:0] l, input logic [1:0] m);
    req_valid = 1'b1;
    req_addr  = a;
    req_len   = l;
    req_mode  = m;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Called in the ISSUE cycle; acts as top_read and returns in the cycle after NEXT.
  task automatic respond();
    rd_busy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rd_busy      = 1'b0;
    rd_completed = 1'b1;
    @(negedge clk);
    rd_completed = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    req_valid = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({req_ready, busy, done, error, err_code, chunk_cnt, rd_read_req,
         rd_start_addr, rd_end_addr, rd_mode, rd_switch_die_need} !==
        {1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_values: got rdy=%b busy=%b done=%b err=%b code=%b cnt=%h req=%b s=%h e=%h",
               req_ready, busy, done, error, err_code, chunk_cnt, rd_read_req, rd_start_addr, rd_end_addr);
    end
    req_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    send(32'h0, 32'h11, 2'b00);
    @(negedge clk);
    n_cmp++;
    if ({rd_read_req, rd_start_addr, rd_end_addr, rd_mode, rd_switch_die_need, busy} !==
        {1'b1, 32'h0, 32'h10, 2'b00, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL single_issue: got req=%b %h..%h mode=%b sw=%b busy=%b, want 1 0..10 00 0 1",
               rd_read_req, rd_start_addr, rd_end_addr, rd_mode, rd_switch_die_need, busy);
    end
    respond();
    n_cmp++;
    if ({done, error, chunk_cnt, rd_read_req, rd_end_addr} !== {1'b1, 1'b0, 16'd1, 1'b0, 32'h10}) begin
      n_bad++;
      $display("FAIL single_done: got done=%b err=%b cnt=%0d req=%b end=%h, want 1 0 1 0 10",
               done, error, chunk_cnt, rd_read_req, rd_end_addr);
    end
    @(negedge clk);
    n_cmp++;
    if ({done, req_ready, busy} !== 3'b010) begin
      n_bad++;
      $display("FAIL single_idle: got done=%b rdy=%b busy=%b, want 0 1 0", done, req_ready, busy);
    end
  endtask

  task automatic test_split();
    send(32'hF0, 32'h20, 2'b10);
    @(negedge clk);
    n_cmp++;
    if ({rd_read_req, rd_start_addr, rd_end_addr, rd_mode, rd_switch_die_need} !==
        {1'b1, 32'hF0, 32'hFF, 2'b10, 1'b0}) begin
      n_bad++;
      $display("FAIL split_chunk1: got req=%b %h..%h mode=%b sw=%b, want 1 f0..ff 10 0",
               rd_read_req, rd_start_addr, rd_end_addr, rd_mode, rd_switch_die_need);
    end
    respond();
    n_cmp++;
    if ({rd_read_req, rd_start_addr, rd_end_addr, rd_mode, rd_switch_die_need, done} !==
        {1'b1, 32'h100, 32'h10F, 2'b10, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL split_chunk2: got req=%b %h..%h mode=%b sw=%b done=%b, want 1 100..10f 10 0 0",
               rd_read_req, rd_start_addr, rd_end_addr, rd_mode, rd_switch_die_need, done);
    end
    respond();
    n_cmp++;
    if ({done, error, chunk_cnt} !== {1'b1, 1'b0, 16'd2}) begin
      n_bad++;
      $display("FAIL split_done: got done=%b err=%b cnt=%0d, want 1 0 2", done, error, chunk_cnt);
    end
    @(negedge clk);
  endtask

  task automatic test_bad();
    logic [31:0] ba [3] = '{32'h0, 32'h1000, 32'hFFFFFFF0};
    logic [31:0] bl [3] = '{32'h0, 32'h4, 32'h20};
    logic [1:0]  bm [3] = '{2'b00, 2'b11, 2'b00};
    for (int i = 0; i < 3; i++) begin
      send(ba[i], bl[i], bm[i]);
      n_cmp++;
      if ({req_ready, busy, rd_read_req} !== 3'b010) begin
        n_bad++;
        $display("FAIL bad%0d_check: got rdy=%b busy=%b req=%b, want 0 1 0", i, req_ready, busy, rd_read_req);
      end
      @(negedge clk);
      n_cmp++;
      if ({error, err_code, req_ready, rd_read_req, done} !== {1'b1, 2'b01, 1'b1, 1'b0, 1'b0}) begin
        n_bad++;
        $display("FAIL bad%0d_error: got err=%b code=%b rdy=%b req=%b done=%b, want 1 01 1 0 0",
                 i, error, err_code, req_ready, rd_read_req, done);
      end
      @(negedge clk);
      n_cmp++;
      if ({error, err_code, rd_read_req} !== {1'b0, 2'b01, 1'b0}) begin
        n_bad++;
        $display("FAIL bad%0d_hold: got err=%b code=%b req=%b, want 0 01 0", i, error, err_code, rd_read_req);
      end
    end
  endtask

  task automatic test_die_cross();
    send(32'h01FFFFF0, 32'h21, 2'b00);
    @(negedge clk);
    n_cmp++;
    if ({rd_read_req, rd_start_addr, rd_end_addr, rd_switch_die_need} !==
        {1'b1, 32'h01FFFFF0, 32'h01FFFFFF, 1'b0}) begin
      n_bad++;
      $display("FAIL die_chunk1: got req=%b %h..%h sw=%b, want 1 01fffff0..01ffffff 0",
               rd_read_req, rd_start_addr, rd_end_addr, rd_switch_die_need);
    end
    respond();
    n_cmp++;
    if ({rd_read_req, rd_start_addr, rd_end_addr, rd_switch_die_need} !==
        {1'b1, 32'h02000000, 32'h02000010, 1'b1}) begin
      n_bad++;
      $display("FAIL die_chunk2: got req=%b %h..%h sw=%b, want 1 02000000..02000010 1",
               rd_read_req, rd_start_addr, rd_end_addr, rd_switch_die_need);
    end
    respond();
    n_cmp++;
    if ({done, chunk_cnt} !== {1'b1, 16'd2}) begin
      n_bad++;
      $display("FAIL die_done: got done=%b cnt=%0d, want 1 2", done, chunk_cnt);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    send(32'h100, 32'h10, 2'b01);
    @(negedge clk);
    n_cmp++;
    if ({rd_read_req, rd_start_addr, rd_end_addr, rd_mode, rd_switch_die_need} !==
        {1'b1, 32'h100, 32'h10F, 2'b01, 1'b1}) begin
      n_bad++;
      $display("FAIL rstmid_issue: got req=%b %h..%h mode=%b sw=%b, want 1 100..10f 01 1",
               rd_read_req, rd_start_addr, rd_end_addr, rd_mode, rd_switch_die_need);
    end
    rd_busy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    rd_busy = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({req_ready, busy, done, error, err_code, chunk_cnt, rd_read_req,
         rd_start_addr, rd_end_addr, rd_mode, rd_switch_die_need} !==
        {1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0}) begin
      n_bad++;
      $display("FAIL rstmid_values: got rdy=%b busy=%b done=%b err=%b code=%b cnt=%h s=%h e=%h mode=%b sw=%b",
               req_ready, busy, done, error, err_code, chunk_cnt, rd_start_addr, rd_end_addr, rd_mode,
               rd_switch_die_need);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({done, error} !== 2'b00) begin
      n_bad++;
      $display("FAIL rstmid_nopulse: got done=%b err=%b, want 0 0", done, error);
    end
    send(32'h100, 32'h10, 2'b01);
    @(negedge clk);
    n_cmp++;
    if ({rd_read_req, rd_start_addr, rd_switch_die_need} !== {1'b1, 32'h100, 1'b0}) begin
      n_bad++;
      $display("FAIL rstmid_lastdie: got req=%b s=%h sw=%b, want 1 100 0",
               rd_read_req, rd_start_addr, rd_switch_die_need);
    end
    respond();
    n_cmp++;
    if ({done, chunk_cnt} !== {1'b1, 16'd1}) begin
      n_bad++;
      $display("FAIL rstmid_done: got done=%b cnt=%0d, want 1 1", done, chunk_cnt);
    end
    @(negedge clk);
  endtask

  task automatic test_abort();
    send(32'h200, 32'h4, 2'b01);
    @(negedge clk);
    n_cmp++;
    if ({rd_read_req, rd_start_addr, rd_end_addr, rd_switch_die_need} !== {1'b1, 32'h200, 32'h203, 1'b0}) begin
      n_bad++;
      $display("FAIL abort_issue: got req=%b %h..%h sw=%b, want 1 200..203 0",
               rd_read_req, rd_start_addr, rd_end_addr, rd_switch_die_need);
    end
    rd_busy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    rd_busy = 1'b0;
    n_cmp++;
    if ({error, err_code, req_ready, done} !== {1'b1, 2'b11, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL abort_error: got err=%b code=%b rdy=%b done=%b, want 1 11 1 0",
               error, err_code, req_ready, done);
    end
    @(negedge clk);
    n_cmp++;
    if ({error, err_code} !== {1'b0, 2'b11}) begin
      n_bad++;
      $display("FAIL abort_hold: got err=%b code=%b, want 0 11", error, err_code);
    end
  endtask

  task automatic test_timeout();
    send(32'h300, 32'h4, 2'b00);
    @(negedge clk);
    repeat (TO) @(negedge clk);
    n_cmp++;
    if ({error, busy} !== 2'b01) begin
      n_bad++;
      $display("FAIL timeout_early: got err=%b busy=%b, want 0 1", error, busy);
    end
    @(negedge clk);
    n_cmp++;
    if ({error, err_code, req_ready} !== {1'b1, 2'b10, 1'b1}) begin
      n_bad++;
      $display("FAIL timeout_error: got err=%b code=%b rdy=%b, want 1 10 1", error, err_code, req_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    send(32'h400, 32'h100, 2'b00);
    n_cmp++;
    if ({err_code, chunk_cnt} !== {2'b00, 16'd0}) begin
      n_bad++;
      $display("FAIL b2b_clear: got code=%b cnt=%0d, want 00 0", err_code, chunk_cnt);
    end
    @(negedge clk);
    n_cmp++;
    if ({rd_read_req, rd_start_addr, rd_end_addr, rd_switch_die_need} !== {1'b1, 32'h400, 32'h4FF, 1'b0}) begin
      n_bad++;
      $display("FAIL b2b_first: got req=%b %h..%h sw=%b, want 1 400..4ff 0",
               rd_read_req, rd_start_addr, rd_end_addr, rd_switch_die_need);
    end
    respond();
    @(negedge clk);
    send(32'h04000010, 32'h8, 2'b10);
    n_cmp++;
    if (chunk_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL b2b_cnt_clear: got cnt=%0d, want 0", chunk_cnt);
    end
    @(negedge clk);
    n_cmp++;
    if ({rd_read_req, rd_start_addr, rd_end_addr, rd_mode, rd_switch_die_need} !==
        {1'b1, 32'h04000010, 32'h04000017, 2'b10, 1'b1}) begin
      n_bad++;
      $display("FAIL b2b_second: got req=%b %h..%h mode=%b sw=%b, want 1 04000010..04000017 10 1",
               rd_read_req, rd_start_addr, rd_end_addr, rd_mode, rd_switch_die_need);
    end
    respond();
    n_cmp++;
    if ({done, error, chunk_cnt} !== {1'b1, 1'b0, 16'd1}) begin
      n_bad++;
      $display("FAIL b2b_done: got done=%b err=%b cnt=%0d, want 1 0 1", done, error, chunk_cnt);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_split();
    test_bad();
    test_die_cross();
    test_reset_mid();
    test_abort();
    test_timeout();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
